ifu_fetch: RTL and testbench

- Instruction fetch unit feeding the NPC Decoder; it is the producer end of the instruction interface the Decoder consumes (op/func3/func7 are slices of `inst`).
- Holds the PC and issues word reads to instruction memory over a request/response interface.
- Presents one fetched instruction at a time with a valid/ready handshake.
- Accepts PC redirects from jal/jalr/branch resolution and discards stale fetches.

---
 rtl/ifu_pkg.sv | 24 ++
 rtl/ifu_pc_gen.sv | 23 ++
 rtl/ifu_fetch.sv | 124 ++++++++++++
 tb/tb_ifu_fetch.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit and the decoder.
package ifu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned PC_STEP  = 4;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam logic [31:0] INST_NOP     = 32'h0000_0013;

  // Major opcode field inst[6:2], shared with the decoder
  localparam logic [4:0] OP_IMM   = 5'b00100;
  localparam logic [4:0] OP_LUI   = 5'b01101;
  localparam logic [4:0] OP_AUIPC = 5'b00101;
  localparam logic [4:0] OP_JAL   = 5'b11011;
  localparam logic [4:0] OP_JALR  = 5'b11001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_HOLD = 2'd3
  } state_t;

endpackage

// File: rtl/ifu_pc_gen.sv
// Next-PC select: redirect target wins, else pc+4 on advance, else hold.
module ifu_pc_gen
  import ifu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] pc,
  input  logic            advance,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] npc_c
);

  always_comb begin
    npc_c = pc;
    if (redirect_valid) begin
      npc_c = redirect_pc;
    end else if (advance) begin
      npc_c = pc + XLEN'(PC_STEP);
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: PC, single-outstanding memory fetch, valid/ready instruction output.
// Optional misaligned-PC trap (nop + fetch_err) under `define IFU_MISALIGN_CHK_EN.
module ifu_fetch
  import ifu_pkg::*;
#(
  parameter int unsigned    XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            fetch_err
);

  state_t          state, state_n;
  logic [XLEN-1:0] pc, npc_c;
  logic            kill, kill_n;
  logic [XLEN-1:0] inst_n, inst_pc_n;
  logic            ferr_n;
  logic            advance_c;
  logic            misalign_c;

  assign mem_req_addr = pc;
  assign advance_c    = (state == S_HOLD) && inst_ready;

  ifu_pc_gen #(.XLEN(XLEN)) u_pc_gen (
    .pc             (pc),
    .advance        (advance_c),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .npc_c          (npc_c)
  );

`ifdef IFU_MISALIGN_CHK_EN
  assign misalign_c = (npc_c[1:0] != 2'b00);
`else
  assign misalign_c = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    kill_n    = kill;
    inst_n    = inst;
    inst_pc_n = inst_pc;
    ferr_n    = fetch_err;
    case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        // A redirect on the accept cycle leaves the old fetch in flight to be dropped
        if (mem_req_ready) begin
          state_n = S_WAIT;
          kill_n  = redirect_valid;
        end
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          kill_n = 1'b0;
          if (kill || redirect_valid) begin
            state_n = S_REQ;
          end else begin
            state_n   = S_HOLD;
            inst_n    = mem_resp_data;
            inst_pc_n = pc;
          end
        end else if (redirect_valid) begin
          kill_n = 1'b1;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) begin
          state_n = S_REQ;
          ferr_n  = 1'b0;
        end
      end
      default: state_n = S_IDLE;
    endcase
    // Misaligned target: skip the memory and present a nop flagged as an error
    if ((state_n == S_REQ) && misalign_c) begin
      state_n   = S_HOLD;
      inst_n    = XLEN'(INST_NOP);
      inst_pc_n = npc_c;
      ferr_n    = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc            <= RESET_PC;
      kill          <= 1'b0;
      inst          <= '0;
      inst_pc       <= '0;
      inst_valid    <= 1'b0;
      mem_req_valid <= 1'b0;
      fetch_err     <= 1'b0;
    end else begin
      pc            <= npc_c;
      kill          <= kill_n;
      inst          <= inst_n;
      inst_pc       <= inst_pc_n;
      inst_valid    <= (state_n == S_HOLD);
      mem_req_valid <= (state_n == S_REQ);
      fetch_err     <= ferr_n;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed scenarios followed by randomized traffic.
module tb_ifu_fetch;

  localparam logic [31:0] RPC = 32'h8000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst;
  logic        mem_req_valid, mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        inst_valid, inst_ready;
  logic [31:0] inst, inst_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_err;

  int n_chk  = 0;
  int n_pass = 0;
  int n_acc  = 0;

  // Memory knobs: mode 0 zero-wait, 1 random, 2 fixed latency
  int          mode    = 0;
  int          fix_lat = 0;
  bit          force_en = 0;
  logic [31:0] force_data = '0;

  logic [31:0] exp_q[$];

  ifu_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .mem_req_valid  (mem_req_valid),
    .mem_req_ready  (mem_req_ready),
    .mem_req_addr   (mem_req_addr),
    .mem_resp_valid (mem_resp_valid),
    .mem_resp_data  (mem_resp_data),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch_err      (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    if (a == RPC) return 32'h0010_0093;
    return (a * 32'h0001_9E37) ^ 32'h5A5A_0001;
  endfunction

  function automatic logic misal(input logic [31:0] a);
`ifdef IFU_MISALIGN_CHK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] a);
    return misal(a) ? NOP : word(a);
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drv();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (inst_valid) begin ok = 1; break; end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  task automatic wait_req(input string name);
    bit ok = 0;
    for (int i = 0; i < 40; i++) begin
      smp();
      if (mem_req_valid) begin ok = 1; break; end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  function automatic logic [31:0] rand_target();
    logic [31:0] r, t;
    r = $urandom;
    if (r[2:0] == 3'd0) t = 32'hFFFF_FFF8;
    else t = RPC + 32'({r[13:4], 2'b00});
`ifdef IFU_MISALIGN_CHK_EN
    if (r[20:18] == 3'd0) t[1:0] = r[1:0];
`endif
    return t;
  endfunction

  // Reference model: next delivered instruction is the last redirect target, else previous+4
  initial begin
    logic [31:0] e;
    bit acc;
    forever begin
      smp();
      if (rst) begin
        exp_q.delete();
        exp_q.push_back(RPC);
        continue;
      end
      acc = inst_valid && inst_ready;
      e = '0;
      if (acc) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          chk("sb_unexpected_inst", inst_pc, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          chk("sb_inst_pc", inst_pc, e);
          chk("sb_inst", inst, exp_inst(e));
          chk("sb_fetch_err", 32'(fetch_err), 32'(misal(e)));
        end
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_q.push_back(redirect_pc);
      end else if (acc) begin
        exp_q.push_back(e + 32'd4);
      end
    end
  end

  // Memory model: one outstanding request, configurable latency, stray responses when idle
  initial begin
    bit          acc, out;
    int          lat;
    logic [31:0] a, ma;
    out = 0; lat = 0; ma = '0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    forever begin
      smp();
      acc = mem_req_valid && mem_req_ready;
      a   = mem_req_addr;
      drv();
      if (acc) begin
        out = 1;
        ma  = a;
        lat = (mode == 1) ? int'($urandom_range(0, 3)) : (mode == 2) ? fix_lat : 0;
`ifdef IFU_MISALIGN_CHK_EN
        chk("req_aligned", 32'(a[1:0]), 32'd0);
`endif
      end
      if (out && lat == 0) begin
        mem_resp_valid = 1'b1;
        mem_resp_data  = force_en ? force_data : word(ma);
        force_en       = 0;
        out            = 0;
        mem_req_ready  = 1'b0;
      end else begin
        if (out) lat--;
        mem_resp_valid = (mode == 1) && !out && ($urandom_range(0, 4) == 0);
        mem_resp_data  = 32'hBAD0_0BAD;
        mem_req_ready  = !out && ((mode != 1) || ($urandom_range(0, 2) != 0));
      end
    end
  end

  initial begin
    int          lat_seen;
    bit          stable, noval, found;
    logic [31:0] hold_i, hold_pc;

    rst = 1'b1; inst_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) drv();
    smp();
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
    chk("rst_fetch_err", 32'(fetch_err), 32'd0);

    // First fetch latency with zero-wait memory
    drv(); rst = 1'b0;
    lat_seen = 99;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (i == 1) begin
        chk("first_req_valid", 32'(mem_req_valid), 32'd1);
        chk("first_req_addr", mem_req_addr, RPC);
      end
      if (inst_valid) begin lat_seen = i; break; end
    end
    chk("first_valid_latency", 32'(lat_seen), 32'd3);
    chk("first_inst", inst, 32'h0010_0093);
    chk("first_inst_pc", inst_pc, RPC);
    smp();
    chk("second_req_valid", 32'(mem_req_valid), 32'd1);
    chk("second_req_addr", mem_req_addr, RPC + 32'd4);
    drv(); inst_ready = 1'b0;

    // Stall in hold: output stable, no new request
    wait_valid("stall_wait_valid");
    hold_i = inst; hold_pc = inst_pc;
    chk("stall_pc", hold_pc, RPC + 32'd4);
    stable = 1;
    repeat (5) begin
      smp();
      if (inst !== hold_i || inst_pc !== hold_pc || !inst_valid || mem_req_valid) stable = 0;
    end
    chk("stall_stable", 32'(stable), 32'd1);
    drv(); inst_ready = 1'b1;
    drv(); inst_ready = 1'b0;
    wait_req("stall_wait_req");
    chk("stall_next_addr", mem_req_addr, hold_pc + 32'd4);

    // Redirect together with accept in hold
    wait_valid("hredir_wait_valid");
    chk("hredir_pc", inst_pc, RPC + 32'd8);
    drv(); inst_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = RPC + 32'h40;
    drv(); redirect_valid = 1'b0;
    wait_req("hredir_wait_req");
    chk("hredir_addr", mem_req_addr, RPC + 32'h40);

    // Redirect while waiting; the late response must be dropped
    mode = 2; fix_lat = 1;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid && mem_req_ready) break;
      smp();
    end
    drv(); redirect_valid = 1'b1; redirect_pc = RPC + 32'h100;
    force_data = 32'hDEAD_BEEF; force_en = 1;
    drv(); redirect_valid = 1'b0;
    noval = 1; found = 0;
    for (int i = 0; i < 20; i++) begin
      smp();
      if (inst_valid) noval = 0;
      if (mem_req_valid) begin found = 1; break; end
    end
    chk("wkill_no_valid", 32'(noval), 32'd1);
    chk("wkill_found_req", 32'(found), 32'd1);
    chk("wkill_addr", mem_req_addr, RPC + 32'h100);

    // Reset while a fetch is in flight; stale response arrives after release
    fix_lat = 3;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_valid && mem_req_ready) break;
      smp();
    end
    drv(); rst = 1'b1; force_data = 32'hBAD0_57A1; force_en = 1;
    drv(); rst = 1'b0;
    wait_valid("rstmid_wait_valid");
    chk("rstmid_inst", inst, 32'h0010_0093);
    chk("rstmid_inst_pc", inst_pc, RPC);

`ifdef IFU_MISALIGN_CHK_EN
    smp(); mode = 0;
    drv(); inst_ready = 1'b0;
    wait_valid("mis_wait_hold");
    drv(); redirect_valid = 1'b1; redirect_pc = RPC + 32'h102;
    drv(); redirect_valid = 1'b0;
    found = 0;
    for (int i = 0; i < 10; i++) begin
      smp();
      if (mem_req_valid) found = 1;
      if (inst_valid && inst_pc == RPC + 32'h102) break;
    end
    chk("mis_no_req", 32'(found), 32'd0);
    chk("mis_inst", inst, NOP);
    chk("mis_inst_pc", inst_pc, RPC + 32'h102);
    chk("mis_fetch_err", 32'(fetch_err), 32'd1);
    drv(); inst_ready = 1'b1;
`endif

    // Randomized traffic against the scoreboard
    smp(); mode = 1;
    for (int i = 0; i < 4000; i++) begin
      drv();
      inst_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 9) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = rand_target();
      end else begin
        redirect_valid = 1'b0;
      end
    end
    drv(); redirect_valid = 1'b0; inst_ready = 1'b1;
    repeat (10) smp();
    chk("accept_count_min", 32'(n_acc >= 300), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
